// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register feeding the writeback result mux.
// Holds the control fields, destination index and the four candidate results
// for one instruction. Each rising edge is resolved in this order: rst, then
// flush, then stall, then capture.
// The reset is synchronous and active-high. All outputs come straight from
// flops, so no input reaches an output combinationally.
// Optional feature: define MEM_WB_RETIRE_CNT_EN to include a 32-bit count of
// instructions retired into WB. With the macro undefined, retire_count is
// tied to 0 and no counter register exists.
module mem_wb_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_m,
  input  logic                      reg_write_m,
  input  logic [1:0]                result_src_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [DATA_WIDTH-1:0]     alu_result_m,
  input  logic [DATA_WIDTH-1:0]     read_data_m,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_m,
  input  logic [DATA_WIDTH-1:0]     imm_ext_m,
  output logic                      valid_w,
  output logic                      reg_write_w,
  output logic [1:0]                result_src_w,
  output logic [REG_ADDR_WIDTH-1:0] rd_w,
  output logic [DATA_WIDTH-1:0]     alu_result_w,
  output logic [DATA_WIDTH-1:0]     read_data_w,
  output logic [DATA_WIDTH-1:0]     pc_plus4_w,
  output logic [DATA_WIDTH-1:0]     imm_ext_w,
  output logic [31:0]               retire_count
);

  logic                      flushEn;
  logic                      captureEn;
  logic                      regWriteGated;

  logic                      valid_q,        valid_d;
  logic                      reg_write_q,    reg_write_d;
  logic [1:0]                result_src_q,   result_src_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,           rd_d;
  logic [DATA_WIDTH-1:0]     alu_result_q,   alu_result_d;
  logic [DATA_WIDTH-1:0]     read_data_q,    read_data_d;
  logic [DATA_WIDTH-1:0]     pc_plus4_q,     pc_plus4_d;
  logic [DATA_WIDTH-1:0]     imm_ext_q,      imm_ext_d;

  // Classify the edge: a flush beats a stall, and only a plain edge captures.
  always_comb begin
    flushEn   = 1'b0;
    captureEn = 1'b0;
    if (flush) begin
      flushEn = 1'b1;
    end else if (!stall) begin
      captureEn = 1'b1;
    end
  end

  // Only a real instruction that targets a register other than x0 may write.
  always_comb begin
    regWriteGated = reg_write_m & valid_m & (rd_m != '0);
  end

  // Next-state select: a bubble on flush, new MEM contents on capture, otherwise hold.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    pc_plus4_d   = pc_plus4_q;
    imm_ext_d    = imm_ext_q;
    if (flushEn) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      result_src_d = 2'b00;
      rd_d         = '0;
      alu_result_d = '0;
      read_data_d  = '0;
      pc_plus4_d   = '0;
      imm_ext_d    = '0;
    end else if (captureEn) begin
      valid_d      = valid_m;
      reg_write_d  = regWriteGated;
      result_src_d = result_src_m;
      rd_d         = rd_m;
      alu_result_d = alu_result_m;
      read_data_d  = read_data_m;
      pc_plus4_d   = pc_plus4_m;
      imm_ext_d    = imm_ext_m;
    end
  end

  // WB register bank; a synchronous reset discards whatever entry is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_ext_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      imm_ext_q    <= imm_ext_d;
    end
  end

  assign valid_w      = valid_q;
  assign reg_write_w  = reg_write_q;
  assign result_src_w = result_src_q;
  assign rd_w         = rd_q;
  assign alu_result_w = alu_result_q;
  assign read_data_w  = read_data_q;
  assign pc_plus4_w   = pc_plus4_q;
  assign imm_ext_w    = imm_ext_q;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  // Count every real instruction captured into WB; the count wraps freely.
  always_comb begin
    retire_d = retire_q;
    if (captureEn && valid_m) begin
      retire_d = retire_q + 32'd1;
    end
  end

  // Retire counter register, cleared by reset and held on stall or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= 32'd0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// tb_mem_wb_reg: directed self-checking bench for mem_wb_reg.
// The expected retire count follows MEM_WB_RETIRE_CNT_EN: it tracks the
// counter when the macro is defined and is 0 otherwise.
module tb_mem_wb_reg;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid_m;
  logic        reg_write_m;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m;
  logic [31:0] read_data_m;
  logic [31:0] pc_plus4_m;
  logic [31:0] imm_ext_m;
  logic        valid_w;
  logic        reg_write_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic [31:0] imm_ext_w;
  logic [31:0] retire_count;

  int          checks;
  int          failures;
  logic [31:0] expCount;

  mem_wb_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .result_src_m (result_src_m),
    .rd_m         (rd_m),
    .alu_result_m (alu_result_m),
    .read_data_m  (read_data_m),
    .pc_plus4_m   (pc_plus4_m),
    .imm_ext_m    (imm_ext_m),
    .valid_w      (valid_w),
    .reg_write_w  (reg_write_w),
    .result_src_w (result_src_w),
    .rd_w         (rd_w),
    .alu_result_w (alu_result_w),
    .read_data_w  (read_data_w),
    .pc_plus4_w   (pc_plus4_w),
    .imm_ext_w    (imm_ext_w),
    .retire_count (retire_count)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expRc(input logic [31:0] c);
`ifdef MEM_WB_RETIRE_CNT_EN
    return c;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] src,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] rdat, input logic [31:0] pc,
                               input logic [31:0] imm);
    valid_m      = v;
    reg_write_m  = rw;
    result_src_m = src;
    rd_m         = rd;
    alu_result_m = alu;
    read_data_m  = rdat;
    pc_plus4_m   = pc;
    imm_ext_m    = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b11, 5'd31, 32'h1111_1111, 32'h2222_2222,
                  32'h3333_3333, 32'h4444_4444);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({valid_w, reg_write_w, result_src_w, rd_w} !== 9'd0) begin
        failures++;
        $display("[TB] FAIL reset_ctl edge=%0d got=%h exp=0", i,
                 {valid_w, reg_write_w, result_src_w, rd_w});
      end
      checks++;
      if ({alu_result_w, read_data_w, pc_plus4_w, imm_ext_w} !== 128'd0) begin
        failures++;
        $display("[TB] FAIL reset_data edge=%0d got=%h exp=0", i,
                 {alu_result_w, read_data_w, pc_plus4_w, imm_ext_w});
      end
      checks++;
      if (retire_count !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_retire edge=%0d got=%h exp=0", i, retire_count);
      end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    expCount = 32'd0;
  endtask

  task automatic test_capture();
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd7, 32'h0000_1111, 32'hDEAD_BEEF,
                  32'h0000_0104, 32'h0000_0055);
    step();
    expCount = expCount + 32'd1;
    checks++;
    if ({valid_w, reg_write_w, result_src_w, rd_w} !== {1'b1, 1'b1, 2'b01, 5'd7}) begin
      failures++;
      $display("[TB] FAIL capture_ctl got=%h exp=%h",
               {valid_w, reg_write_w, result_src_w, rd_w}, {1'b1, 1'b1, 2'b01, 5'd7});
    end
    checks++;
    if (read_data_w !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL capture_rdata got=%h exp=deadbeef", read_data_w);
    end
    checks++;
    if ({alu_result_w, pc_plus4_w, imm_ext_w} !== {32'h0000_1111, 32'h0000_0104, 32'h0000_0055}) begin
      failures++;
      $display("[TB] FAIL capture_data got=%h", {alu_result_w, pc_plus4_w, imm_ext_w});
    end
    checks++;
    if (retire_count !== expRc(expCount)) begin
      failures++;
      $display("[TB] FAIL capture_retire got=%h exp=%h", retire_count, expRc(expCount));
    end
    // Invalid entry with write enable: data still captured, no write, no retire.
    applyStimulus(1'b0, 1'b1, 2'b00, 5'd9, 32'hA5A5_0000, 32'h0, 32'h0, 32'h0);
    step();
    checks++;
    if ({valid_w, reg_write_w, rd_w} !== {1'b0, 1'b0, 5'd9}) begin
      failures++;
      $display("[TB] FAIL invalid_ctl got=%h exp=%h", {valid_w, reg_write_w, rd_w},
               {1'b0, 1'b0, 5'd9});
    end
    checks++;
    if (alu_result_w !== 32'hA5A5_0000) begin
      failures++;
      $display("[TB] FAIL invalid_data got=%h exp=a5a50000", alu_result_w);
    end
    checks++;
    if (retire_count !== expRc(expCount)) begin
      failures++;
      $display("[TB] FAIL invalid_retire got=%h exp=%h", retire_count, expRc(expCount));
    end
  endtask

  task automatic test_x0_write();
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    step();
    expCount = expCount + 32'd1;
    checks++;
    if ({valid_w, reg_write_w, rd_w} !== {1'b1, 1'b0, 5'd0}) begin
      failures++;
      $display("[TB] FAIL x0_ctl got=%h exp=%h", {valid_w, reg_write_w, rd_w},
               {1'b1, 1'b0, 5'd0});
    end
    checks++;
    if (retire_count !== expRc(expCount)) begin
      failures++;
      $display("[TB] FAIL x0_retire got=%h exp=%h", retire_count, expRc(expCount));
    end
  endtask

  task automatic test_flush_stall();
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd7, 32'h10, 32'h20, 32'h30, 32'h40);
    step();
    expCount = expCount + 32'd1;
    checks++;
    if (rd_w !== 5'd7) begin
      failures++;
      $display("[TB] FAIL pre_flush_rd got=%0d exp=7", rd_w);
    end
    stall = 1'b1; flush = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b10, 5'd9, 32'h99, 32'h98, 32'h97, 32'h96);
    step();
    checks++;
    if ({valid_w, reg_write_w, result_src_w, rd_w} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL flush_ctl got=%h exp=0", {valid_w, reg_write_w, result_src_w, rd_w});
    end
    checks++;
    if ({alu_result_w, read_data_w, pc_plus4_w, imm_ext_w} !== 128'd0) begin
      failures++;
      $display("[TB] FAIL flush_data got=%h exp=0",
               {alu_result_w, read_data_w, pc_plus4_w, imm_ext_w});
    end
    checks++;
    if (retire_count !== expRc(expCount)) begin
      failures++;
      $display("[TB] FAIL flush_retire got=%h exp=%h", retire_count, expRc(expCount));
    end
  endtask

  task automatic test_stall_hold();
    stall = 1'b0; flush = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b10, 5'd12, 32'h0000_0A0A, 32'h0000_0B0B,
                  32'h0000_0200, 32'h0000_0C0C);
    step();
    expCount = expCount + 32'd1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b01, 5'(i + 20), 32'hFFFF_0000 + 32'(i), 32'h1,
                    32'h2, 32'h3);
      step();
      checks++;
      if ({valid_w, reg_write_w, result_src_w, rd_w} !== {1'b1, 1'b1, 2'b10, 5'd12}) begin
        failures++;
        $display("[TB] FAIL stall_ctl edge=%0d got=%h exp=%h", i,
                 {valid_w, reg_write_w, result_src_w, rd_w}, {1'b1, 1'b1, 2'b10, 5'd12});
      end
      checks++;
      if ({alu_result_w, read_data_w, pc_plus4_w, imm_ext_w} !==
          {32'h0000_0A0A, 32'h0000_0B0B, 32'h0000_0200, 32'h0000_0C0C}) begin
        failures++;
        $display("[TB] FAIL stall_data edge=%0d got=%h", i,
                 {alu_result_w, read_data_w, pc_plus4_w, imm_ext_w});
      end
      checks++;
      if (retire_count !== expRc(expCount)) begin
        failures++;
        $display("[TB] FAIL stall_retire edge=%0d got=%h exp=%h", i, retire_count,
                 expRc(expCount));
      end
    end
    // Flush alone with a valid entry must not count.
    stall = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({valid_w, rd_w, retire_count} !== {1'b0, 5'd0, expRc(expCount)}) begin
      failures++;
      $display("[TB] FAIL flush_only got=%h exp=%h", {valid_w, rd_w, retire_count},
               {1'b0, 5'd0, expRc(expCount)});
    end
  endtask

  task automatic test_wrap();
`ifdef MEM_WB_RETIRE_CNT_EN
    stall = 1'b1;
    force dut.retire_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_q;
    expCount = 32'hFFFF_FFFE;
    #1;
    stall = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 5'd1, 32'(i), 32'h0, 32'h0, 32'h0);
      step();
      expCount = expCount + 32'd1;
      checks++;
      if (retire_count !== expRc(expCount)) begin
        failures++;
        $display("[TB] FAIL wrap_retire step=%0d got=%h exp=%h", i, retire_count,
                 expRc(expCount));
      end
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b1, 1'b1, 2'b11, 5'd5, 32'h5, 32'h6, 32'h7, 32'h8);
    step();
    rst = 1'b1; stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b11, 5'd6, 32'h9, 32'hA, 32'hB, 32'hC);
    step();
    expCount = 32'd0;
    checks++;
    if ({valid_w, reg_write_w, result_src_w, rd_w, alu_result_w, read_data_w,
         pc_plus4_w, imm_ext_w, retire_count} !== 169'd0) begin
      failures++;
      $display("[TB] FAIL midreset_all valid=%b rd=%0d alu=%h retire=%h exp=0",
               valid_w, rd_w, alu_result_w, retire_count);
    end
    rst = 1'b0; stall = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd3, 32'h0000_0777, 32'h0, 32'h0, 32'h0);
    step();
    expCount = expCount + 32'd1;
    checks++;
    if ({valid_w, reg_write_w, rd_w, alu_result_w} !== {1'b1, 1'b1, 5'd3, 32'h0000_0777}) begin
      failures++;
      $display("[TB] FAIL post_reset_ctl got=%h", {valid_w, reg_write_w, rd_w, alu_result_w});
    end
    checks++;
    if (retire_count !== expRc(expCount)) begin
      failures++;
      $display("[TB] FAIL post_reset_retire got=%h exp=%h", retire_count, expRc(expCount));
    end
  endtask

  task automatic test_back_to_back();
    logic        tV    [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        tRw   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  tSrc  [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [4:0]  tRd   [4] = '{5'd3, 5'd4, 5'd5, 5'd31};
    logic [31:0] tData [4] = '{32'h0000_0010, 32'hFFFF_F800, 32'h1234_5678, 32'h8000_0004};
    logic        eRw   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tV[i], tRw[i], tSrc[i], tRd[i], tData[i], ~tData[i],
                    tData[i] + 32'd4, tData[i] ^ 32'h0F0F_0F0F);
      step();
      if (tV[i]) expCount = expCount + 32'd1;
      checks++;
      if ({valid_w, reg_write_w, result_src_w, rd_w} !== {tV[i], eRw[i], tSrc[i], tRd[i]}) begin
        failures++;
        $display("[TB] FAIL b2b_ctl idx=%0d got=%h exp=%h", i,
                 {valid_w, reg_write_w, result_src_w, rd_w}, {tV[i], eRw[i], tSrc[i], tRd[i]});
      end
      checks++;
      if ({alu_result_w, read_data_w, pc_plus4_w, imm_ext_w} !==
          {tData[i], ~tData[i], tData[i] + 32'd4, tData[i] ^ 32'h0F0F_0F0F}) begin
        failures++;
        $display("[TB] FAIL b2b_data idx=%0d got=%h", i,
                 {alu_result_w, read_data_w, pc_plus4_w, imm_ext_w});
      end
      checks++;
      if (retire_count !== expRc(expCount)) begin
        failures++;
        $display("[TB] FAIL b2b_retire idx=%0d got=%h exp=%h", i, retire_count,
                 expRc(expCount));
      end
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    checks = 0;
    failures = 0;
    expCount = 32'd0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    test_reset();
    test_capture();
    test_x0_write();
    test_flush_stall();
    test_stall_hold();
    test_wrap();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
